// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and elaboration-time checks for the pipelined lookahead adder.
package cla_pipe_adder_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_BLOCK = 4;

   // True when the operand width splits into a whole number of lookahead groups.
   function automatic bit width_ok(input int width, input int block);
      return (block > 0) && (width >= block) && ((width % block) == 0);
   endfunction

endpackage

// File: rtl/cla_group.sv
// One BLOCK-bit carry-lookahead group: generate/propagate with every internal
// carry expanded into sum-of-products form, so no carry ripples inside the group.
module cla_group
   import cla_pipe_adder_pkg::*;
#(
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   carry;
   logic             term;

   assign g = a & b;
   assign p = a ^ b;

   // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i]).
   always_comb begin
      // NOTE: combinational logic uses blocking assignments, and every variable gets a default first so no latch is inferred.
      carry    = '0;
      term     = 1'b0;
      carry[0] = cin;
      for (int i = 0; i < BLOCK; i++) begin
         carry[i+1] = cin;
         for (int j = 0; j <= i; j++) begin
            carry[i+1] = carry[i+1] & p[j];
         end
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) begin
               term = term & p[m];
            end
            carry[i+1] = carry[i+1] | term;
         end
      end
   end

   assign sum  = p ^ carry[BLOCK-1:0];
   assign cout = carry[BLOCK];
   assign cmsb = carry[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Carry-pipelined lookahead adder/subtractor on a valid/ready stream. Stage k
// resolves group k and registers the group carry into stage k+1; the whole
// pipeline advances together whenever the output register is free or drained.
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSTAGES = WIDTH / BLOCK;

   if (!width_ok(WIDTH, BLOCK)) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
   end

   logic                 adv;
   logic [NSTAGES-1:0]   st_valid;
   logic [NSTAGES-1:0]   st_carry;
   logic [WIDTH-1:0]     st_a    [NSTAGES];
   logic [WIDTH-1:0]     st_b    [NSTAGES];
   logic [WIDTH-1:0]     st_sum  [NSTAGES];
   logic [WIDTH-1:0]     grp_sum;
   logic [NSTAGES-1:0]   grp_cout;
   logic                 grp_cmsb [NSTAGES];
   logic [WIDTH-1:0]     res_sum [NSTAGES];

   // The pipeline moves as a unit: it advances unless a result is stuck at the output.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      cla_group #(.BLOCK(BLOCK)) u_group (
         .a    (st_a[k][k*BLOCK +: BLOCK]),
         .b    (st_b[k][k*BLOCK +: BLOCK]),
         .cin  (st_carry[k]),
         .sum  (grp_sum[k*BLOCK +: BLOCK]),
         .cout (grp_cout[k]),
         .cmsb (grp_cmsb[k])
      );
   end

   // Merge each stage's freshly resolved group into the sum bits it carries forward.
   always_comb begin
      for (int k = 0; k < NSTAGES; k++) begin
         res_sum[k]                    = st_sum[k];
         res_sum[k][k*BLOCK +: BLOCK]  = grp_sum[k*BLOCK +: BLOCK];
      end
   end

   // Control and output registers: valid bits and reported results, cleared by rst.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         st_valid  <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv) begin
         st_valid[0] <= in_valid;
         for (int k = 1; k < NSTAGES; k++) begin
            st_valid[k] <= st_valid[k-1];
         end
         out_valid <= st_valid[NSTAGES-1];
         if (st_valid[NSTAGES-1]) begin
            sum  <= res_sum[NSTAGES-1];
            cout <= grp_cout[NSTAGES-1];
            ovf  <= grp_cmsb[NSTAGES-1] ^ grp_cout[NSTAGES-1];
         end
      end
   end

   // Datapath registers: operands, carries and partial sums shift with the valid bits.
   always_ff @(posedge clk) begin
      // NOTE: datapath registers have no reset; their contents are only observed behind a valid bit.
      if (adv) begin
         st_a[0]     <= a;
         st_b[0]     <= sub ? ~b : b;
         st_carry[0] <= sub ? 1'b1 : cin;
         st_sum[0]   <= '0;
         for (int k = 1; k < NSTAGES; k++) begin
            st_a[k]     <= st_a[k-1];
            st_b[k]     <= st_b[k-1];
            st_carry[k] <= grp_cout[k-1];
            st_sum[k]   <= res_sum[k-1];
         end
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, BLOCK=4): directed vector
// table, reset/flush/bubble sequences and randomized streams against an
// arithmetic reference model with an in-order expectation queue.
module tb_cla_pipe_adder;

   localparam int WIDTH = 16;
   localparam int BLOCK = 4;
   localparam int LAT   = WIDTH / BLOCK;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      res_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;
   bit   mon_en   = 1'b0;
   res_t exp_q[$];
   res_t prev_out;
   bit   prev_stall = 1'b0;

   cla_pipe_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mcin, input logic msub);
      int   ua = ma;
      int   ub = mb;
      int   sa = $signed(ma);
      int   sb = $signed(mb);
      int   u;
      int   s;
      res_t r;
      if (msub) begin
         u      = ua - ub;
         s      = sa - sb;
         r.cout = (ua >= ub);
      end else begin
         u      = ua + ub + int'(mcin);
         s      = sa + sb + int'(mcin);
         r.cout = (u > 65535);
      end
      r.sum = u[15:0];
      r.ovf = (s > 32767) || (s < -32768);
      return r;
   endfunction

   // Stream monitor: in_ready rule, stall hold, and in-order result scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else if (mon_en) begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (prev_stall) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", {sum, cout, ovf}, prev_out);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got 0x%0h expected no result", {sum, cout, ovf});
            end else begin
               check("stream_result", {sum, cout, ovf}, exp_q.pop_front());
               pops++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
         prev_stall = out_valid && !out_ready;
         prev_out   = {sum, cout, ovf};
      end
   end

   // Issue one op into an idle pipeline and measure cycles until out_valid.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic isub, output res_t got, output int lat);
      a = ia; b = ib; cin = icin; sub = isub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      got = {sum, cout, ovf};
      @(posedge clk); #1;
   endtask

   // Random stream of n ops; out_ready alternates 1,0,... or is random.
   task automatic stream(input int n, input bit alt_ready, input int budget);
      int  sent = 0;
      int  base = pops;
      int  c    = 0;
      bit  acc;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      while ((pops - base < n) && c < budget) begin
         if (!in_valid) in_valid = (sent < n) && (alt_ready || ($urandom_range(3) != 0));
         out_ready = alt_ready ? (c % 2 == 0) : 1'($urandom_range(1));
         #1;
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            in_valid = 1'b0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         end
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("stream_count", pops - base, n);
      check("stream_queue_empty", exp_q.size(), 0);
   endtask

   vec_t vecs[11];
   res_t got;
   int   lat;
   bit   seen;
   int   hits;
   int   hit_cyc[$];

   initial begin
      vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
      vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
      vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
      vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}};
      vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
      vecs[5]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
      vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
      vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
      vecs[8]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, '{16'h0002, 1'b1, 1'b0}};
      vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
      vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}};

      // Reset held two cycles with operands presented: nothing may be captured.
      rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, 16'h0000);
      check("rst_cout", cout, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen |= out_valid;
      end
      check("rst_nothing_emerges", seen, 1'b0);
      mon_en = 1'b1;

      // Directed vectors, one at a time, with latency measurement.
      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, got, lat);
         check($sformatf("vec%0d_result", i), got, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), lat, LAT);
      end

      // Eight back-to-back ops with out_ready toggling 1,0,1,0.
      stream(8, 1'b1, 400);

      // Three ops in flight, then a one-cycle reset: all three must vanish.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("flush_out_valid", out_valid, 1'b0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         seen |= out_valid;
      end
      check("flush_nothing_emerges", seen, 1'b0);
      issue(16'hABCD, 16'h1357, 1'b1, 1'b0, got, lat);
      check("flush_new_result", got, model(16'hABCD, 16'h1357, 1'b1, 1'b0));
      check("flush_new_latency", lat, LAT);

      // Bubble pattern in_valid 1,0,0,1: two results, three cycles apart.
      hit_cyc.delete();
      for (int c = 0; c < 12; c++) begin
         in_valid  = (c == 0) || (c == 3);
         out_ready = 1'b1;
         a = 16'(c * 16'h1111); b = 16'h0101; cin = 1'b0; sub = 1'b0;
         @(posedge clk); #1;
         if (out_valid) hit_cyc.push_back(c);
      end
      in_valid = 1'b0;
      hits = hit_cyc.size();
      check("bubble_count", hits, 2);
      if (hits == 2) begin
         check("bubble_first_cycle", hit_cyc[0], LAT);
         check("bubble_gap", hit_cyc[1] - hit_cyc[0], 3);
      end

      // Longer randomized stream with random valid and ready.
      stream(40, 1'b0, 2000);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, carry-pipelined carry-lookahead adder/subtractor for WIDTH-bit operands.
- Operands are split into BLOCK-bit lookahead groups. Each group is resolved in its own pipeline stage, and the group carry is registered into the next stage.
- Sits between operand sources and result consumers on a valid/ready stream. It is the clocked, wide, back-pressurable successor to the team's fixed 4-bit lookahead adder.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of BLOCK, otherwise elaboration fails.
- BLOCK, 4, lookahead group width in bits; NSTAGES = WIDTH/BLOCK pipeline stages.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits, out_valid, sum, cout and ovf go to 0 on the next edge. In-flight operations are discarded and never emerge. rst dominates in_valid.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv, combinational, with no dependency on in_valid.
- Accept: a transfer occurs when in_valid & in_ready.
- Stall: when adv=0, every pipeline register and every output holds its value.
- Stage k (0..NSTAGES-1) holds:
  - the valid bit;
  - the registered carry into group k;
  - sum bits for groups 0..k-1, already resolved;
  - the unresolved operand slices for groups k..NSTAGES-1, with B already inverted if sub.
- On advance, stage k computes group k with the combinational lookahead block (g=a&b, p=a^b, full lookahead within the group). It passes the resolved sum bits and carry-out to stage k+1.
- The last stage also computes ovf from the group carry into bit WIDTH-1 and the final carry. Its results register into sum/cout/ovf, and out_valid is set.
- Stage-0 carry-in = sub ? 1 : cin.
- Latency: a result is accepted at edge t and out_valid=1 after edge t+NSTAGES-1+1, i.e. NSTAGES cycles, with no stall.
- Throughput: 1 result per cycle.
- Ordering: strict FIFO order. No reordering, no drops, no duplicates.
- Bubbles: an advance with no accepted input shifts a valid=0 bubble. Bubbles never raise out_valid.
- Output hold: outputs hold stable while out_valid & ~out_ready.
- Simultaneous accept at stage 0 and drain at the output in the same cycle is legal and sustains full rate.
- Arithmetic is modulo 2^WIDTH. sum wraps and the overflow is reported only via cout/ovf.
- BLOCK=WIDTH is legal: NSTAGES=1, latency 1.

Decomposition:
- Shared package: default WIDTH/BLOCK constants and an elaboration-time check function for WIDTH % BLOCK == 0.
- One sub-module, cla_group:
  - combinational, parametrised by BLOCK;
  - inputs: a slice, b slice, carry-in;
  - outputs: sum slice, carry-out, carry into its MSB (for ovf).
- cla_pipe_adder instantiates NSTAGES copies of cla_group.

Test Plan (WIDTH=16, BLOCK=4, latency 4):
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, sum=0x0000, cout=0, ovf=0, and in_ready=1 after release.
- a=0xFFFF, b=0x0001, cin=0, sub=0 accepted at cycle t -> at cycle t+4, out_valid=1, sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 registered groups).
- Edge cases:
  - a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0, b=0, cin=1 -> sum=0x0001.
- Stream of 8 random vectors back-to-back with out_ready pattern 1,0,1,0,... -> results in issue order match a golden model. in_ready=0 exactly in cycles with out_valid=1 and out_ready=0. No loss or duplication. Output is held stable during the stall.
- Three ops in flight, pulse rst for 1 cycle -> out_valid=0 from the next edge, none of the three results ever appears, and a new op issued afterwards returns after exactly 4 cycles.
- Bubble pattern: in_valid=1,0,0,1 with out_ready=1 -> exactly 2 results, 3 cycles apart, out_valid=0 between them.
